// File: rtl/sync_fifo_flags.sv
// Single-clock parametrised FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and read-while-full pass-through.
// Build option: define FIFO_FWFT_EN for first-word-fall-through read data.
module sync_fifo_flags #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 8,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_rq,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       rd_rq,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       clr_err,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] LAST_IDX = PW'(DEPTH - 1);

  // Thresholds outside the occupancy range can never behave sensibly.
  if (AF_THRESH > DEPTH || AE_THRESH >= DEPTH) begin : g_bad_thresh
    $error("sync_fifo_flags: AF_THRESH must be <= DEPTH and AE_THRESH < DEPTH");
  end

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic [WIDTH-1:0] r_rdata;
  logic             r_ovf;
  logic             r_unf;

  logic             w_full;
  logic             w_empty;
  logic             w_rd_acc;
  logic             w_wr_acc;
  logic [WIDTH-1:0] w_head;

  // Status decodes of the registered count.
  always_comb begin
    w_full       = (int'(r_count) == DEPTH);
    w_empty      = (r_count == '0);
    almost_full  = (int'(r_count) >= AF_THRESH);
    almost_empty = (AE_THRESH >= 0) && (int'(r_count) <= AE_THRESH);
  end

  // Acceptance: a read frees a slot, so a full FIFO still takes a write alongside it.
  always_comb begin
    w_rd_acc = rd_rq & ~w_empty;
    w_wr_acc = wr_rq & (~w_full | w_rd_acc);
    w_head   = r_mem[r_rptr];
  end

  // Storage array; deliberately not reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc && !reset) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  // Pointers with explicit wrap at DEPTH-1, and the occupancy counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr_acc) r_wptr <= (r_wptr == LAST_IDX) ? '0 : r_wptr + 1'b1;
      if (w_rd_acc) r_rptr <= (r_rptr == LAST_IDX) ? '0 : r_rptr + 1'b1;
      if (w_wr_acc && !w_rd_acc)      r_count <= r_count + 1'b1;
      else if (w_rd_acc && !w_wr_acc) r_count <= r_count - 1'b1;
    end
  end

  // Sticky error flags; a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else begin
      r_ovf <= (wr_rq & ~w_wr_acc) | (r_ovf & ~clr_err);
      r_unf <= (rd_rq & ~w_rd_acc) | (r_unf & ~clr_err);
    end
  end

`ifdef FIFO_FWFT_EN
  // Remember the word currently presented so it is held once the FIFO drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (!w_empty) begin
      r_rdata <= w_head;
    end
  end

  // Head of queue falls through whenever there is something to show.
  always_comb begin
    rdata = w_empty ? r_rdata : w_head;
  end
`else
  // Registered read: loaded on an accepted read, held otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdata <= '0;
    end else if (w_rd_acc) begin
      r_rdata <= w_head;
    end
  end

  // Drive the read port from the output register.
  always_comb begin
    rdata = r_rdata;
  end
`endif

  // Output port drives.
  always_comb begin
    full      = w_full;
    empty     = w_empty;
    count     = r_count;
    overflow  = r_ovf;
    underflow = r_unf;
  end

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Directed bench for sync_fifo_flags at default parameters.
// Inputs change 1 ns after a rising edge; outputs are checked at that same point.
module tb_sync_fifo_flags;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_rq = 1'b0;
  logic [3:0] wdata = '0;
  logic       rd_rq = 1'b0;
  logic [3:0] rdata;
  logic       full, empty, almost_full, almost_empty;
  logic [3:0] count;
  logic       clr_err = 1'b0;
  logic       overflow, underflow;

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] sb [$];
  logic [3:0] exp_d;

  sync_fifo_flags dut (
    .clk(clk), .reset(reset), .wr_rq(wr_rq), .wdata(wdata), .rd_rq(rd_rq),
    .rdata(rdata), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count), .clr_err(clr_err),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset state, then fill with 1..8
    reset = 1'b1; tick(); reset = 1'b0;
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_ae", almost_empty, 1);
    chk("rst_af", almost_full, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_unf", underflow, 0);
    for (int i = 1; i <= 8; i++) begin
      wr_rq = 1'b1; wdata = 4'(i); tick();
      chk("fill_count", count, i);
      chk("fill_ae", almost_empty, (i <= 1) ? 1 : 0);
      chk("fill_af", almost_full, (i >= 6) ? 1 : 0);
      chk("fill_full", full, (i == 8) ? 1 : 0);
      chk("fill_empty", empty, 0);
    end
    wr_rq = 1'b0;
    chk("fill_ovf", overflow, 0);

    // 2: overflow is sticky until cleared; set wins over clear
    wr_rq = 1'b1; wdata = 4'hF; tick(); wr_rq = 1'b0;
    chk("ovf_set", overflow, 1);
    chk("ovf_count", count, 8);
    tick();
    chk("ovf_sticky", overflow, 1);
    clr_err = 1'b1; wr_rq = 1'b1; tick(); wr_rq = 1'b0;
    chk("ovf_setwins", overflow, 1);
    tick(); clr_err = 1'b0;
    chk("ovf_clr", overflow, 0);

    // 3: simultaneous read/write while full, then drain
    wr_rq = 1'b1; rd_rq = 1'b1; wdata = 4'hA; tick(); wr_rq = 1'b0;
    chk("rwf_rdata", rdata, 1);
    chk("rwf_count", count, 8);
    chk("rwf_ovf", overflow, 0);
    for (int i = 2; i <= 8; i++) begin
      tick();
      chk("drain_rdata", rdata, i);
      chk("drain_count", count, 9 - i);
    end
    tick(); rd_rq = 1'b0;
    chk("drain_last", rdata, 4'hA);
    chk("drain_empty", empty, 1);
    chk("drain_count0", count, 0);

    // 4: underflow on empty; both requests on empty only write
    rd_rq = 1'b1; tick(); rd_rq = 1'b0;
    chk("unf_set", underflow, 1);
    chk("unf_rdata", rdata, 4'hA);
    chk("unf_count", count, 0);
    wr_rq = 1'b1; rd_rq = 1'b1; wdata = 4'h3; tick(); wr_rq = 1'b0; rd_rq = 1'b0;
    chk("emp_rw_count", count, 1);
    chk("emp_rw_rdata", rdata, 4'hA);
    chk("emp_rw_unf", underflow, 1);
    clr_err = 1'b1; tick(); clr_err = 1'b0;
    chk("unf_clr", underflow, 0);
    rd_rq = 1'b1; tick(); rd_rq = 1'b0;
    chk("emp_rw_data", rdata, 3);
    chk("emp_rw_empty", empty, 1);

    // 5: wrap-around with a scoreboard: prefill 3, then 20 simultaneous pairs
    for (int i = 0; i < 3; i++) begin
      wr_rq = 1'b1; wdata = 4'($urandom_range(0, 15)); sb.push_back(wdata); tick();
    end
    wr_rq = 1'b0;
    chk("wrap_pre", count, 3);
    for (int i = 0; i < 20; i++) begin
      wr_rq = 1'b1; rd_rq = 1'b1; wdata = 4'($urandom_range(0, 15));
      sb.push_back(wdata); exp_d = sb.pop_front(); tick();
      chk("wrap_data", rdata, exp_d);
      chk("wrap_count", count, 3);
    end
    wr_rq = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_d = sb.pop_front(); tick();
      chk("wrap_drain", rdata, exp_d);
    end
    rd_rq = 1'b0;
    chk("wrap_empty", empty, 1);

    // 6: reset mid-burst at count 5 with errors pending
    rd_rq = 1'b1; tick(); rd_rq = 1'b0;
    chk("r6_unf", underflow, 1);
    for (int i = 0; i < 5; i++) begin
      wr_rq = 1'b1; wdata = 4'(i + 9); tick();
    end
    chk("r6_count5", count, 5);
    reset = 1'b1; tick(); reset = 1'b0; wr_rq = 1'b0;
    chk("r6_count", count, 0);
    chk("r6_empty", empty, 1);
    chk("r6_rdata", rdata, 0);
    chk("r6_ovf", overflow, 0);
    chk("r6_unf0", underflow, 0);
    wr_rq = 1'b1; wdata = 4'h6; tick(); wr_rq = 1'b0;
`ifdef FIFO_FWFT_EN
    chk("r6_fwft", rdata, 6);
`else
    chk("r6_noread", rdata, 0);
    rd_rq = 1'b1; tick(); rd_rq = 1'b0;
    chk("r6_read", rdata, 6);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sync_fifo_flags.md
Name: sync_fifo_flags

Overview:
Single-clock, parametrised FIFO. It is the successor of the team's basic 4-bit × 8-entry FIFO and adds:
- arbitrary depth and width
- occupancy count
- programmable almost-full and almost-empty thresholds
- sticky overflow and underflow error flags
- read-while-full pass-through

It sits between a producer and a consumer in the same clock domain, and it is also the storage stage behind the clock-divider-driven test harnesses.

Parameters:
WIDTH, 4, data word width in bits (≥1)
DEPTH, 8, number of entries (≥2, any integer; it need not be a power of two)
AF_THRESH, DEPTH-2, almost_full asserts when count ≥ AF_THRESH
AE_THRESH, 1, almost_empty asserts when count ≤ AE_THRESH

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
wr_rq  input  1  write request
wdata  input  WIDTH  write data, sampled on an accepted write
rd_rq  input  1  read request (a pop when FIFO_FWFT_EN is defined)
rdata  output  WIDTH  read data
full  output  1  count == DEPTH
empty  output  1  count == 0
almost_full  output  1  count ≥ AF_THRESH
almost_empty  output  1  count ≤ AE_THRESH
count  output  $clog2(DEPTH+1)  current occupancy
clr_err  input  1  clears the sticky error flags
overflow  output  1  sticky: a write was rejected
underflow  output  1  sticky: a read was rejected

Behaviour:
- Reset, when reset=1 at a clock edge:
  - wptr=0, rptr=0, count=0, rdata=0, overflow=0, underflow=0.
  - Outputs after reset: empty=1, full=0, almost_empty=1 (when AE_THRESH ≥ 0), almost_full=0.
  - Storage contents are not cleared.
  - Reset dominates every other input. A reset in the middle of a burst discards all contents.
- Acceptance rules, evaluated on the pre-edge state:
  - rd_acc = rd_rq & ~empty
  - wr_acc = wr_rq & (~full | rd_acc)
  - Full with both requests: both are accepted, count is unchanged, and the oldest word is read while the new word is written into the freed slot.
  - Empty with both requests: only the write is accepted. There is no bypass. underflow is set.
- Pointers:
  - wptr advances on wr_acc; rptr advances on rd_acc.
  - Each pointer wraps from DEPTH-1 to 0 explicitly. Modulo-2^n wrap is not allowed.
- Count update:
  - count+1 on wr_acc & ~rd_acc
  - count-1 on rd_acc & ~wr_acc
  - otherwise unchanged
- Flags: full, empty, almost_full and almost_empty are combinational decodes of the registered count. They therefore reflect the new occupancy in the cycle after the edge.
- Error flags:
  - overflow set when wr_rq & ~wr_acc.
  - underflow set when rd_rq & ~rd_acc.
  - Both hold until a clock edge with clr_err=1.
  - If clr_err and a new error event occur in the same cycle, set wins.
- Read data in standard mode (macro undefined):
  - rdata is registered, loaded with mem[rptr] on rd_acc, and valid in the cycle after the accepted request.
  - rdata holds its value when there is no accepted read.
- Write data: mem[wptr] <= wdata on wr_acc.
- Threshold sanity: AF_THRESH > DEPTH or AE_THRESH ≥ DEPTH is a parameter error. Flag it with an elaboration-time check.

Optional Feature:
- Macro: FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rdata continuously presents mem[rptr] while empty=0.
  - rd_rq acts as a pop acknowledge for the word already on rdata.
  - After a write into an empty FIFO, the word appears on rdata in the cycle after that write edge.
  - While empty=1, rdata holds its last value.
- Undefined: standard registered read with one-cycle latency, as described under Behaviour.
- Acceptance, count, flag and error rules are identical in both modes.

Test Plan:
1. Defaults (WIDTH=4, DEPTH=8, AF_THRESH=6, AE_THRESH=1). Reset, then write 1..8 on consecutive cycles → count steps 1..8; almost_empty drops at count 2; almost_full at count 6; full at count 8; overflow still 0.
2. Full FIFO, one more write of 0xF → overflow=1, count stays 8. Then clr_err for one cycle → overflow=0.
3. Full FIFO, wr_rq=rd_rq=1 with wdata=0xA → rdata=1 next cycle (standard mode), count stays 8. After 7 plain reads, rdata sequence is 2..8; the following read returns 0xA.
4. Empty FIFO, rd_rq=1 → underflow=1, rdata unchanged, count 0. Then wr_rq=rd_rq=1 with wdata=0x3 → only the write is accepted, count=1.
5. Wrap-around: 20 interleaved write/read pairs with $random data checked against a scoreboard → data order preserved across pointer wrap at 7→0; count never exceeds 8.
6. Reset asserted mid-burst at count=5 → next cycle count=0, empty=1, rdata=0, overflow=underflow=0. With FIFO_FWFT_EN defined, a write of 0x6 then shows rdata=0x6 one cycle later, before any rd_rq.
